mem_access: RTL and testbench

Memory-access stage between execute and register write-back. Takes the execute result (address or ALU value) plus store data and access size, and drives a single-outstanding valid/ready data-memory bus with an 8-byte-aligned address, shifted write mask and shifted write data. It registers the returned raw 64-bit doubleword into the write-back pipeline register, where the write-back mux performs lane extraction and sign/zero extension. It stalls upstream while a memory transaction is outstanding and flags misaligned accesses instead of issuing them.

---
 rtl/mem_access.sv | 157 +++++++++++++++
 tb/tb_mem_access.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: issues one aligned valid/ready data-memory transaction at a time,
// stalls upstream while it is outstanding, and registers results into the write-back register.
module mem_access (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [63:0] ex_alu_result,
    input  logic [63:0] ex_rs2_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_ext_un,
    input  logic [7:0]  ex_byte_enable,
    output logic        stall,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [63:0] dmem_addr,
    output logic        dmem_wen,
    output logic [7:0]  dmem_wmask,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_resp_valid,
    input  logic [63:0] dmem_rdata,
    output logic        wb_valid,
    output logic [63:0] wb_alu_result,
    output logic [63:0] wb_mem_data,
    output logic        wb_mem_to_reg,
    output logic        wb_mem_ext_un,
    output logic        wb_misalign,
    output logic [7:0]  wb_byte_enable
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q;
    logic        req_valid_q;
    logic [63:0] addr_q;
    logic        wen_q;
    logic [7:0]  wmask_q;
    logic [63:0] wdata_q;
    logic        ext_un_q;
    logic [7:0]  be_q;
    logic [63:0] alu_q;
    logic        wb_valid_q;
    logic [63:0] wb_alu_q;
    logic [63:0] wb_mem_data_q;
    logic        wb_mem_to_reg_q;
    logic        wb_ext_un_q;
    logic        wb_misalign_q;
    logic [7:0]  wb_be_q;

    logic        mem_op_d;
    logic [15:0] lane_mask_d;
    logic        misaligned_d;
    logic        accept_d;
    logic [63:0] addr_d;
    logic [7:0]  wmask_d;
    logic [63:0] wdata_d;

    // Any lane pushed past byte 7 means the access straddles a doubleword.
    assign mem_op_d     = ex_valid & (ex_mem_read | ex_mem_write);
    assign lane_mask_d  = {8'h00, ex_byte_enable} << ex_alu_result[2:0];
    assign misaligned_d = mem_op_d & (|lane_mask_d[15:8]);
    assign accept_d     = mem_op_d & ~misaligned_d;
    assign addr_d       = {ex_alu_result[63:3], 3'b000};
    assign wmask_d      = ex_mem_write ? lane_mask_d[7:0] : 8'h00;
    assign wdata_d      = ex_rs2_data << {ex_alu_result[2:0], 3'b000};

    // Stall rises in the accepting cycle itself so upstream holds the instruction.
    assign stall = reset_n & ((state_q != IDLE) | accept_d);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            req_valid_q     <= 1'b0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wmask_q         <= '0;
            wdata_q         <= '0;
            ext_un_q        <= 1'b0;
            be_q            <= '0;
            alu_q           <= '0;
            wb_valid_q      <= 1'b0;
            wb_alu_q        <= '0;
            wb_mem_data_q   <= '0;
            wb_mem_to_reg_q <= 1'b0;
            wb_ext_un_q     <= 1'b0;
            wb_misalign_q   <= 1'b0;
            wb_be_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        addr_q      <= addr_d;
                        wen_q       <= ex_mem_write;
                        wmask_q     <= wmask_d;
                        wdata_q     <= wdata_d;
                        ext_un_q    <= ex_mem_ext_un;
                        be_q        <= ex_byte_enable;
                        alu_q       <= ex_alu_result;
                        req_valid_q <= 1'b1;
                        wb_valid_q  <= 1'b0;
                        state_q     <= REQ;
                    end else if (ex_valid) begin
                        wb_valid_q      <= 1'b1;
                        wb_alu_q        <= ex_alu_result;
                        wb_mem_data_q   <= '0;
                        wb_mem_to_reg_q <= ex_mem_read & ~misaligned_d;
                        wb_ext_un_q     <= ex_mem_ext_un;
                        wb_misalign_q   <= misaligned_d;
                        wb_be_q         <= ex_byte_enable;
                    end else begin
                        wb_valid_q <= 1'b0;
                    end
                end
                REQ: begin
                    wb_valid_q <= 1'b0;
                    if (dmem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_resp_valid) begin
                        wb_valid_q      <= 1'b1;
                        wb_alu_q        <= alu_q;
                        wb_mem_data_q   <= wen_q ? 64'h0 : dmem_rdata;
                        wb_mem_to_reg_q <= ~wen_q;
                        wb_ext_un_q     <= ext_un_q;
                        wb_misalign_q   <= 1'b0;
                        wb_be_q         <= be_q;
                        state_q         <= IDLE;
                    end else begin
                        wb_valid_q <= 1'b0;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                    wb_valid_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = addr_q;
    assign dmem_wen       = wen_q;
    assign dmem_wmask     = wmask_q;
    assign dmem_wdata     = wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_alu_result  = wb_alu_q;
    assign wb_mem_data    = wb_mem_data_q;
    assign wb_mem_to_reg  = wb_mem_to_reg_q;
    assign wb_mem_ext_un  = wb_ext_un_q;
    assign wb_misalign    = wb_misalign_q;
    assign wb_byte_enable = wb_be_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized memory and ALU traffic
// checked against an arithmetic model of the bus request and write-back results.
module tb_mem_access;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [63:0] ex_alu_result;
    logic [63:0] ex_rs2_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_ext_un;
    logic [7:0]  ex_byte_enable;
    logic        stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [7:0]  dmem_wmask;
    logic [63:0] dmem_wdata;
    logic        dmem_resp_valid;
    logic [63:0] dmem_rdata;
    logic        wb_valid;
    logic [63:0] wb_alu_result;
    logic [63:0] wb_mem_data;
    logic        wb_mem_to_reg;
    logic        wb_mem_ext_un;
    logic        wb_misalign;
    logic [7:0]  wb_byte_enable;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_access dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_ext_un(ex_mem_ext_un), .ex_byte_enable(ex_byte_enable),
        .stall(stall), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_mem_ext_un(wb_mem_ext_un),
        .wb_misalign(wb_misalign), .wb_byte_enable(wb_byte_enable)
    );

    // Drives one load/store through the stage and checks every cycle against the model.
    task automatic run_mem_op(input logic rd, input logic [63:0] a, input logic [63:0] rs2,
                              input logic [7:0] be, input logic un, input int rdy_dly,
                              input int rsp_dly, input logic [63:0] rdata);
        int          off, span;
        logic        mis;
        logic [63:0] e_addr, e_wdata, e_mdata;
        logic [7:0]  e_mask;
        off     = int'(a[2:0]);
        span    = (be == 8'h01) ? 1 : (be == 8'h03) ? 2 : (be == 8'h0F) ? 4 : 8;
        mis     = (off + span) > 8;
        e_addr  = a - 64'(off);
        e_mask  = rd ? 8'h00 : 8'(((1 << span) - 1) << off);
        e_wdata = rs2 << (8 * off);
        e_mdata = rd ? rdata : 64'h0;
        @(posedge clock); #1;
        ex_valid = 1'b1; ex_alu_result = a; ex_rs2_data = rs2; ex_mem_read = rd;
        ex_mem_write = !rd; ex_mem_ext_un = un; ex_byte_enable = be;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
        @(negedge clock);
        if (mis) begin
            checks++;
            if (stall !== 1'b0 || dmem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL mis_accept stall=%0b req_valid=%0b required 0/0", stall, dmem_req_valid);
            end
            @(posedge clock); #1;
            ex_valid = 1'b0;
            @(negedge clock);
            checks++;
            if ({wb_valid, wb_misalign, wb_mem_to_reg} !== 3'b110) begin
                failures++;
                $display("FAIL mis_wb valid/misalign/to_reg=%b required 110",
                         {wb_valid, wb_misalign, wb_mem_to_reg});
            end
            checks++;
            if (wb_alu_result !== a || wb_mem_data !== 64'h0 || wb_byte_enable !== be) begin
                failures++;
                $display("FAIL mis_wb_fields alu=%h data=%h be=%h required %h 0 %h",
                         wb_alu_result, wb_mem_data, wb_byte_enable, a, be);
            end
            checks++;
            if (dmem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL mis_no_req req_valid=%0b required 0", dmem_req_valid);
            end
        end else begin
            checks++;
            if (stall !== 1'b1 || dmem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL accept stall=%0b req_valid=%0b required 1/0", stall, dmem_req_valid);
            end
            @(posedge clock); #1;
            for (int k = 0; k <= rdy_dly; k++) begin
                dmem_req_ready = (k == rdy_dly);
                @(negedge clock);
                checks++;
                if (dmem_req_valid !== 1'b1 || stall !== 1'b1 || wb_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL req_phase req_valid=%0b stall=%0b wb_valid=%0b required 1/1/0",
                             dmem_req_valid, stall, wb_valid);
                end
                checks++;
                if (dmem_addr !== e_addr || dmem_wen !== (!rd) || dmem_wmask !== e_mask ||
                    dmem_wdata !== e_wdata) begin
                    failures++;
                    $display("FAIL req_fields addr=%h wen=%0b mask=%h wdata=%h required %h %0b %h %h",
                             dmem_addr, dmem_wen, dmem_wmask, dmem_wdata, e_addr, !rd, e_mask, e_wdata);
                end
                @(posedge clock); #1;
            end
            dmem_req_ready = 1'b0;
            for (int k = 0; k <= rsp_dly; k++) begin
                dmem_resp_valid = (k == rsp_dly);
                dmem_rdata = (k == rsp_dly) ? rdata : {$urandom, $urandom};
                @(negedge clock);
                checks++;
                if (dmem_req_valid !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL wait_phase req_valid=%0b stall=%0b wb_valid=%0b required 0/1/0",
                             dmem_req_valid, stall, wb_valid);
                end
                @(posedge clock); #1;
            end
            dmem_resp_valid = 1'b0; ex_valid = 1'b0; dmem_rdata = {$urandom, $urandom};
            @(negedge clock);
            checks++;
            if (wb_valid !== 1'b1 || stall !== 1'b0) begin
                failures++;
                $display("FAIL wb_pulse wb_valid=%0b stall=%0b required 1/0", wb_valid, stall);
            end
            checks++;
            if (wb_mem_data !== e_mdata || wb_mem_to_reg !== rd || wb_misalign !== 1'b0) begin
                failures++;
                $display("FAIL wb_mem data=%h to_reg=%0b misalign=%0b required %h %0b 0",
                         wb_mem_data, wb_mem_to_reg, wb_misalign, e_mdata, rd);
            end
            checks++;
            if (wb_alu_result !== a || wb_byte_enable !== be || wb_mem_ext_un !== un) begin
                failures++;
                $display("FAIL wb_pass alu=%h be=%h un=%0b required %h %h %0b",
                         wb_alu_result, wb_byte_enable, wb_mem_ext_un, a, be, un);
            end
        end
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (wb_valid !== 1'b0 || dmem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_op wb_valid=%0b req_valid=%0b required 0/0", wb_valid, dmem_req_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (stall !== 1'b0 || dmem_req_valid !== 1'b0 || dmem_wen !== 1'b0 || dmem_wmask !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl stall=%0b req=%0b wen=%0b mask=%h required all 0",
                     stall, dmem_req_valid, dmem_wen, dmem_wmask);
        end
        checks++;
        if (dmem_addr !== 64'h0 || dmem_wdata !== 64'h0) begin
            failures++;
            $display("FAIL reset_bus addr=%h wdata=%h required 0", dmem_addr, dmem_wdata);
        end
        checks++;
        if ({wb_valid, wb_mem_to_reg, wb_mem_ext_un, wb_misalign} !== 4'b0 || wb_byte_enable !== 8'h00 ||
            wb_alu_result !== 64'h0 || wb_mem_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_wb flags=%b be=%h alu=%h data=%h required all 0",
                     {wb_valid, wb_mem_to_reg, wb_mem_ext_un, wb_misalign}, wb_byte_enable,
                     wb_alu_result, wb_mem_data);
        end
    endtask

    // Back-to-back ALU ops, one per cycle; the first is the directed 0x1234 case.
    task automatic test_alu_ops();
        logic [63:0] prev_a;
        logic        prev_un;
        for (int i = 0; i < 17; i++) begin
            @(posedge clock); #1;
            ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_byte_enable = 8'h00;
            ex_alu_result = (i == 0) ? 64'h1234 : {$urandom, $urandom};
            ex_rs2_data = {$urandom, $urandom}; ex_mem_ext_un = 1'($urandom);
            @(negedge clock);
            checks++;
            if (stall !== 1'b0 || dmem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL alu_stall stall=%0b req=%0b required 0/0", stall, dmem_req_valid);
            end
            if (i > 0) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_alu_result !== prev_a || wb_mem_to_reg !== 1'b0 ||
                    wb_mem_ext_un !== prev_un || wb_misalign !== 1'b0 || wb_mem_data !== 64'h0) begin
                    failures++;
                    $display("FAIL alu_wb valid=%0b alu=%h to_reg=%0b un=%0b mis=%0b required 1 %h 0 %0b 0",
                             wb_valid, wb_alu_result, wb_mem_to_reg, wb_mem_ext_un, wb_misalign,
                             prev_a, prev_un);
                end
            end
            prev_a = ex_alu_result; prev_un = ex_mem_ext_un;
        end
        @(posedge clock); #1;
        ex_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (wb_valid !== 1'b1 || wb_alu_result !== prev_a) begin
            failures++;
            $display("FAIL alu_last valid=%0b alu=%h required 1 %h", wb_valid, wb_alu_result, prev_a);
        end
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL alu_idle wb_valid=%0b required 0", wb_valid);
        end
    endtask

    task automatic test_load_byte();
        run_mem_op(1'b1, 64'h8000_0005, {$urandom, $urandom}, 8'h01, 1'b0, 0, 0, 64'h8877_6655_4433_2211);
    endtask

    task automatic test_store_half();
        run_mem_op(1'b0, 64'h0000_0000_4000_1006, 64'hABCD, 8'h03, 1'b0, 3, 2, {$urandom, $urandom});
    endtask

    task automatic test_misaligned();
        run_mem_op(1'b1, 64'h0000_0000_4000_2006, 64'h0, 8'h0F, 1'b0, 0, 0, 64'h0);
        run_mem_op(1'b0, 64'h0000_0000_4000_2001, 64'h55, 8'hFF, 1'b0, 0, 0, 64'h0);
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clock); #1;
        ex_valid = 1'b1; ex_alu_result = 64'h0000_0000_0000_0010; ex_rs2_data = 64'h0;
        ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_byte_enable = 8'hFF; ex_mem_ext_un = 1'b0;
        @(posedge clock); #1;
        dmem_req_ready = 1'b1;
        @(posedge clock); #1;
        dmem_req_ready = 1'b0; ex_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (dmem_req_valid !== 1'b0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_wait req=%0b stall=%0b required 0/1", dmem_req_valid, stall);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || dmem_req_valid !== 1'b0 || wb_valid !== 1'b0 || dmem_addr !== 64'h0 ||
            wb_alu_result !== 64'h0 || wb_byte_enable !== 8'h00) begin
            failures++;
            $display("FAIL rst_async stall=%0b req=%0b wb=%0b addr=%h alu=%h be=%h required all 0",
                     stall, dmem_req_valid, wb_valid, dmem_addr, wb_alu_result, wb_byte_enable);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        dmem_resp_valid = 1'b1; dmem_rdata = {$urandom, $urandom};
        @(posedge clock); #1;
        dmem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (wb_valid !== 1'b0 || dmem_req_valid !== 1'b0 || stall !== 1'b0) begin
                failures++;
                $display("FAIL rst_late_resp wb=%0b req=%0b stall=%0b required 0/0/0",
                         wb_valid, dmem_req_valid, stall);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        run_mem_op(1'b1, 64'h0000_0001_0000_0008, 64'h0, 8'hFF, 1'b0, 0, 0, {$urandom, $urandom});
        @(posedge clock); #1;
        dmem_resp_valid = 1'b1; dmem_rdata = {$urandom, $urandom};
        @(negedge clock);
        checks++;
        if (stall !== 1'b0 || dmem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle stall=%0b req=%0b required 0/0", stall, dmem_req_valid);
        end
        @(posedge clock); #1;
        dmem_resp_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_spurious wb_valid=%0b required 0", wb_valid);
        end
        run_mem_op(1'b1, 64'h0000_0001_0000_0010, 64'h0, 8'hFF, 1'b1, 1, 1, {$urandom, $urandom});
    endtask

    task automatic test_random_mem();
        logic [7:0]  be;
        logic [63:0] a;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: be = 8'h01;
                1: be = 8'h03;
                2: be = 8'h0F;
                default: be = 8'hFF;
            endcase
            a = {$urandom, $urandom};
            run_mem_op(1'($urandom), a, {$urandom, $urandom}, be, 1'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
        end
    endtask

    initial begin
        reset_n = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_rs2_data = '0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_ext_un = 1'b0; ex_byte_enable = '0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clock);
        test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        test_alu_ops();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_reset_mid_wait();
        test_back_to_back();
        test_random_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
